// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// emits them MSB first, one bit per clock, with frame start/end markers.
module serial_word_feeder #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             flush,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       gcnt;
  logic             last_bit;
  logic             accept;

  // Handshake: a word is taken on a rising edge where word_valid and
  // word_ready are both high; word_ready never depends on word_valid.
  // With GAP==0 the last-bit cycle also accepts, giving bubble-free streams.
  assign last_bit   = (state == S_SHIFT) && (cnt == LAST);
  assign word_ready = !rst && !flush &&
                      ((state == S_IDLE) || (last_bit && (GAP == 0)));
  assign accept     = word_valid && word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        shreg <= '0;
        cnt   <= '0;
        gcnt  <= '0;
      end else if (accept) begin
        shreg <= word_in;
        cnt   <= '0;
      end else if (state == S_SHIFT) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        if (cnt == LAST) begin
          cnt  <= '0;
          gcnt <= GAP_LOAD;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if ((state == S_GAP) && (gcnt != 4'd0)) begin
        gcnt <= gcnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else if (accept) begin
      state_nxt = S_SHIFT;
    end else begin
      case (state)
        S_SHIFT: if (cnt == LAST) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
        S_GAP:   if (gcnt == 4'd0) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_out     = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    busy        = (state != S_IDLE);
    if (state == S_SHIFT) begin
      bit_out     = shreg[WIDTH-1];
      bit_valid   = 1'b1;
      frame_start = (cnt == '0);
      frame_end   = (cnt == LAST);
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Cycle-accurate directed bench for serial_word_feeder: one instance with
// GAP=0 and one with GAP=2, driven from a table of per-cycle vectors.
module tb_serial_word_feeder;

  typedef struct {
    int         sel;
    bit         chk;
    logic       rst;
    logic       flush;
    logic       valid;
    logic [7:0] word;
    logic       ready;
    logic       bo;
    logic       bv;
    logic       fs;
    logic       fe;
    logic       busy;
  } vec_t;

  logic       clk;
  logic       r0, f0, v0;
  logic [7:0] w0;
  logic       rd0, bo0, bv0, fs0, fe0, bz0;
  logic       r2, f2, v2;
  logic [7:0] w2;
  logic       rd2, bo2, bv2, fs2, fe2, bz2;

  int   tests;
  int   fails;
  vec_t vq[$];

  serial_word_feeder #(.WIDTH(8), .GAP(0)) dut0 (
    .clk(clk), .rst(r0), .word_in(w0), .word_valid(v0), .word_ready(rd0),
    .flush(f0), .bit_out(bo0), .bit_valid(bv0), .frame_start(fs0),
    .frame_end(fe0), .busy(bz0)
  );

  serial_word_feeder #(.WIDTH(8), .GAP(2)) dut2 (
    .clk(clk), .rst(r2), .word_in(w2), .word_valid(v2), .word_ready(rd2),
    .flush(f2), .bit_out(bo2), .bit_valid(bv2), .frame_start(fs2),
    .frame_end(fe2), .busy(bz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input int sel, input bit chk, input logic r, input logic f,
                     input logic v, input logic [7:0] w, input logic rd,
                     input logic bo, input logic bv, input logic fs,
                     input logic fe, input logic bz);
    vec_t t;
    t.sel = sel; t.chk = chk; t.rst = r; t.flush = f; t.valid = v; t.word = w;
    t.ready = rd; t.bo = bo; t.bv = bv; t.fs = fs; t.fe = fe; t.busy = bz;
    vq.push_back(t);
  endtask

  // Eight shift cycles of one word; valid for the next word rises at vstart.
  task automatic add_frame(input int sel, input logic [7:0] pat, input int vstart,
                           input logic [7:0] nw, input logic rdy_last);
    for (int k = 0; k < 8; k++) begin
      logic v;
      v = (k >= vstart);
      add(sel, 1, 0, 0, v, v ? nw : 8'h00, (k == 7) ? rdy_last : 1'b0,
          pat[7-k], 1, k == 0, k == 7, 1);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic a_rd, a_bo, a_bv, a_fs, a_fe, a_bz;
    @(negedge clk);
    if (t.sel == 0) begin
      r0 = t.rst; f0 = t.flush; v0 = t.valid; w0 = t.word;
      r2 = 0; f2 = 0; v2 = 0; w2 = 0;
    end else begin
      r2 = t.rst; f2 = t.flush; v2 = t.valid; w2 = t.word;
      r0 = 0; f0 = 0; v0 = 0; w0 = 0;
    end
    #1;
    if (t.chk) begin
      if (t.sel == 0) begin
        a_rd = rd0; a_bo = bo0; a_bv = bv0; a_fs = fs0; a_fe = fe0; a_bz = bz0;
      end else begin
        a_rd = rd2; a_bo = bo2; a_bv = bv2; a_fs = fs2; a_fe = fe2; a_bz = bz2;
      end
      check("word_ready", idx, a_rd, t.ready);
      check("bit_out", idx, a_bo, t.bo);
      check("bit_valid", idx, a_bv, t.bv);
      check("frame_start", idx, a_fs, t.fs);
      check("frame_end", idx, a_fe, t.fe);
      check("busy", idx, a_bz, t.busy);
    end
  endtask

  initial begin
    int fs_cyc[$];
    tests = 0;
    fails = 0;
    r0 = 1; f0 = 0; v0 = 0; w0 = 0;
    r2 = 1; f2 = 0; v2 = 0; w2 = 0;

    // dut0 (GAP=0): reset
    add(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    // single word 0xA5
    add(0, 1, 0, 0, 1, 8'hA5, 1, 0, 0, 0, 0, 0);
    add_frame(0, 8'b10100101, 8, 8'h00, 1);
    add(0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    // back-to-back 0xA5, 0x0F
    add(0, 1, 0, 0, 1, 8'hA5, 1, 0, 0, 0, 0, 0);
    add_frame(0, 8'b10100101, 0, 8'h0F, 1);
    add_frame(0, 8'b00001111, 8, 8'h00, 1);
    add(0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    // valid raised mid-frame at E+3, captured once at E+8
    add(0, 1, 0, 0, 1, 8'hA5, 1, 0, 0, 0, 0, 0);
    add_frame(0, 8'b10100101, 2, 8'h3C, 1);
    add_frame(0, 8'b00111100, 8, 8'h00, 1);
    add(0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    // flush at E+4 of 0xFF; word offered during flush is refused
    add(0, 1, 0, 0, 1, 8'hFF, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 1);
    add(0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 8'h05, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 8'h05, 1, 0, 0, 0, 0, 0);
    add_frame(0, 8'b00000101, 8, 8'h00, 1);
    add(0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    // rst at E+3 of 0xC3 with a word waiting
    add(0, 1, 0, 0, 1, 8'hC3, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 1);
    add(0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
    add(0, 1, 1, 0, 1, 8'h81, 0, 0, 1, 0, 0, 1);
    add(0, 1, 1, 0, 1, 8'h81, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 8'h81, 1, 0, 0, 0, 0, 0);
    add_frame(0, 8'b10000001, 8, 8'h00, 1);
    add(0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0);

    // dut2 (GAP=2): two queued words
    add(2, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(2, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(2, 1, 0, 0, 1, 8'hA5, 1, 0, 0, 0, 0, 0);
    add_frame(2, 8'b10100101, 0, 8'h5A, 0);
    add(2, 1, 0, 0, 1, 8'h5A, 0, 0, 0, 0, 0, 1);
    add(2, 1, 0, 0, 1, 8'h5A, 0, 0, 0, 0, 0, 1);
    add(2, 1, 0, 0, 1, 8'h5A, 1, 0, 0, 0, 0, 0);
    add_frame(2, 8'b01011010, 8, 8'h00, 0);
    add(2, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(2, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(2, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Sustained GAP=2 stream: frame_start every WIDTH+GAP+1 = 11 cycles.
    r0 = 0; f0 = 0; v0 = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      v2 = 1; w2 = 8'h96;
      #1;
      if (fs2) fs_cyc.push_back(c);
      if (fs_cyc.size() == 3) break;
    end
    @(negedge clk);
    v2 = 0;
    tests++;
    if (fs_cyc.size() != 3) begin
      fails++;
      $display("FAIL stream_starts: got %0d frame starts expected 3", fs_cyc.size());
    end else begin
      check("stream_period_1", 0, (fs_cyc[1] - fs_cyc[0]) == 11, 1'b1);
      check("stream_period_2", 1, (fs_cyc[2] - fs_cyc[1]) == 11, 1'b1);
    end
    repeat (12) @(negedge clk);
    #1;
    check("drain_busy", 0, bz2, 1'b0);
    check("drain_ready", 0, rd2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
